// File: rtl/pipe_test_pkg.sv
// Shared definitions for the pipe test logic: pattern codes, LFSR step and
// the transmitter FSM state type. Used by both the driver and checker sides.
package pipe_test_pkg;

    localparam logic [2:0] PAT_FIXED = 3'd0;
    localparam logic [2:0] PAT_COUNT = 3'd1;
    localparam logic [2:0] PAT_LFSR  = 3'd2;
    localparam logic [2:0] PAT_WALK  = 3'd3;

    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        STROBE   = 3'd2,
        BURST    = 3'd3,
        FINISH   = 3'd4
    } state_t;

    // One LFSR step: shift left, feedback from taps 31, 21, 1, 0.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

endpackage

// File: rtl/bt_pipe_in_driver_if.sv
// Block-throttled pipe-in endpoint bus between the driver and a pipe-in sink.
//
// Handshake: the sink raises ep_ready when it can take one whole block. The
// driver answers with a one-cycle ep_blockstrobe, then delivers the block as
// ep_write pulses, each carrying ep_dataout in the same cycle; ep_ready is not
// consulted again until the block has been fully written. ep_dataout is 0
// whenever ep_write is 0, and a strobe never coincides with a write.
interface bt_pipe_in_driver_if;
    logic        ep_ready;
    logic        ep_write;
    logic        ep_blockstrobe;
    logic [31:0] ep_dataout;

    modport master (
        input  ep_ready,
        output ep_write,
        output ep_blockstrobe,
        output ep_dataout
    );

    modport slave (
        output ep_ready,
        input  ep_write,
        input  ep_blockstrobe,
        input  ep_dataout
    );
endinterface

// File: rtl/pipe_pattern_gen.sv
// Pattern word generator. `word` always holds the next word to be sent;
// `load` latches the pattern and presents its first word, `advance` steps to
// the following word. The checker side instantiates the same block.
module pipe_pattern_gen
    import pipe_test_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    input  logic [2:0]  pattern,
    input  logic [31:0] fixed,
    output logic [31:0] word
);

    logic [2:0]  pat_q;
    logic [31:0] first_word;

    // First word of the selected pattern (constant, counter/walk start at 1, LFSR at seed).
    always_comb begin
        first_word = LFSR_SEED;
        case (pattern)
            PAT_FIXED: first_word = fixed;
            PAT_COUNT: first_word = 32'h0000_0001;
            PAT_WALK:  first_word = 32'h0000_0001;
            default:   first_word = LFSR_SEED;
        endcase
    end

    // Pattern latch and word update; load wins over advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q <= PAT_FIXED;
            word  <= 32'h0;
        end else if (load) begin
            pat_q <= pattern;
            word  <= first_word;
        end else if (advance) begin
            case (pat_q)
                PAT_FIXED: word <= word;
                PAT_COUNT: word <= word + 32'd1;
                PAT_WALK:  word <= {word[30:0], word[31]};
                default:   word <= lfsr_next(word);
            endcase
        end
    end

endmodule

// File: rtl/bt_pipe_in_driver.sv
// On-chip okBTPipeIn-style transmitter: sends `length` pattern words to a
// pipe-in sink in blocks of BLOCK_WORDS, each block announced by a strobe
// once the sink is ready, with writes gated by a rotating throttle mask.
// All outputs are registered; they are computed from the next state.
module bt_pipe_in_driver
    import pipe_test_pkg::*;
#(
    parameter int BLOCK_WORDS = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         length,
    input  logic [2:0]          pattern,
    input  logic [31:0]         fixed_pattern,
    input  logic                throttle_set,
    input  logic [31:0]         throttle_val,
    bt_pipe_in_driver_if.master ep,
    output logic                busy,
    output logic                done,
    output logic [31:0]         words_sent,
    output state_t              dbg_state
);

    localparam logic [31:0] BLK = 32'(BLOCK_WORDS);

    state_t      state_q, state_d;
    logic [31:0] thr_q, thr_d;
    logic [31:0] remaining_q, remaining_d;
    logic [31:0] blk_left_q, blk_left_d;
    logic [31:0] blk_size;
    logic [31:0] words_sent_d;
    logic        write_q, write_d;
    logic        strobe_q, strobe_d;
    logic [31:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        gen_load;
    logic [31:0] gen_word;

    pipe_pattern_gen u_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (gen_load),
        .advance (write_d),
        .pattern (pattern),
        .fixed   (fixed_pattern),
        .word    (gen_word)
    );

    // Next state, block bookkeeping, throttle rotation and next-cycle outputs.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        blk_left_d   = blk_left_q;
        words_sent_d = words_sent;
        gen_load     = 1'b0;
        blk_size     = (remaining_q > BLK) ? BLK : remaining_q;
        thr_d        = throttle_set ? throttle_val : {thr_q[0], thr_q[31:1]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    words_sent_d = 32'h0;
                    if (length != 32'h0) begin
                        state_d     = WAIT_RDY;
                        remaining_d = length;
                        gen_load    = 1'b1;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            WAIT_RDY: begin
                if (ep.ep_ready) begin
                    state_d     = STROBE;
                    blk_left_d  = blk_size;
                    remaining_d = remaining_q - blk_size;
                end
            end
            STROBE: state_d = BURST;
            BURST: begin
                // write_q is the write currently on the bus; the block ends with it.
                if (write_q) begin
                    blk_left_d = blk_left_q - 32'd1;
                    if (blk_left_q == 32'd1) begin
                        state_d = (remaining_q == 32'h0) ? FINISH : WAIT_RDY;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        write_d  = (state_d == BURST) && thr_d[0];
        strobe_d = (state_d == STROBE);
        data_d   = write_d ? gen_word : 32'h0;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == FINISH);
        if (write_d) begin
            words_sent_d = words_sent_d + 32'd1;
        end
    end

    // State, throttle and registered outputs; reset drops any partial block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            thr_q       <= 32'hFFFF_FFFF;
            remaining_q <= 32'h0;
            blk_left_q  <= 32'h0;
            write_q     <= 1'b0;
            strobe_q    <= 1'b0;
            data_q      <= 32'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            words_sent  <= 32'h0;
        end else begin
            state_q     <= state_d;
            thr_q       <= thr_d;
            remaining_q <= remaining_d;
            blk_left_q  <= blk_left_d;
            write_q     <= write_d;
            strobe_q    <= strobe_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            words_sent  <= words_sent_d;
        end
    end

    assign ep.ep_write       = write_q;
    assign ep.ep_blockstrobe = strobe_q;
    assign ep.ep_dataout     = data_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_bt_pipe_in_driver.sv
// Bench for bt_pipe_in_driver with BLOCK_WORDS=4: directed scenarios plus
// randomized transfers, all checked by a queue-based scoreboard.
module tb_bt_pipe_in_driver;
    import pipe_test_pkg::*;

    localparam int BW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] length = 32'h0;
    logic [2:0]  pattern = 3'd0;
    logic [31:0] fixed_pattern = 32'h0;
    logic        throttle_set = 1'b0;
    logic [31:0] throttle_val = 32'h0;
    logic        busy, done;
    logic [31:0] words_sent;
    state_t      dbg_state;

    bt_pipe_in_driver_if ep_if ();

    bt_pipe_in_driver #(.BLOCK_WORDS(BW)) dut (
        .clk           (clk),
        .reset         (rst),
        .start         (start),
        .length        (length),
        .pattern       (pattern),
        .fixed_pattern (fixed_pattern),
        .throttle_set  (throttle_set),
        .throttle_val  (throttle_val),
        .ep            (ep_if.master),
        .busy          (busy),
        .done          (done),
        .words_sent    (words_sent),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int passes = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic fail_event(input string name);
        checks++;
        $display("FAIL %s: event seen, required none", name);
    endtask

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int          blk_q[$];
    int          len_q[$];
    int          wr_cyc_q[$];
    int          strobe_cyc_q[$];
    int          done_cyc_q[$];

    int          cyc = 0;
    logic [31:0] thr_m = 32'hFFFF_FFFF;
    int          wr_total = 0;
    int          strobe_total = 0;
    int          done_total = 0;
    int          done_base = 0;
    bit          blk_active = 1'b0;
    int          blk_cnt = 0;
    int          blk_exp = 0;
    bit          prev_write = 1'b0;
    int          mon_len = 0;

    // Cycle count and throttle mask as the protocol defines it.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) thr_m <= 32'hFFFF_FFFF;
        else if (throttle_set) thr_m <= throttle_val;
        else thr_m <= {thr_m[0], thr_m[31:1]};
    end

    // Monitor: observes the bus mid-cycle and pops expectations.
    always @(negedge clk) begin
        if (rst) begin
            blk_active = 1'b0;
            prev_write = 1'b0;
        end else begin
            if (ep_if.ep_write) begin
                wr_total++;
                wr_cyc_q.push_back(cyc);
                check32("throttle_gate", 32'(thr_m[0]), 32'd1);
                check32("no_strobe_with_write", 32'(ep_if.ep_blockstrobe), 32'd0);
                if (exp_q.size() == 0) fail_event("unexpected_write");
                else check32("write_data", ep_if.ep_dataout, exp_q.pop_front());
                blk_cnt++;
            end else begin
                check32("idle_data_zero", ep_if.ep_dataout, 32'h0);
            end
            if (ep_if.ep_blockstrobe) begin
                strobe_total++;
                strobe_cyc_q.push_back(cyc);
                if (blk_active) check32("block_size", 32'(blk_cnt), 32'(blk_exp));
                if (blk_q.size() == 0) begin
                    fail_event("unexpected_strobe");
                    blk_exp = 0;
                end else begin
                    blk_exp = blk_q.pop_front();
                end
                blk_active = 1'b1;
                blk_cnt = 0;
            end
            if (done) begin
                done_total++;
                done_cyc_q.push_back(cyc);
                if (blk_active) check32("last_block_size", 32'(blk_cnt), 32'(blk_exp));
                blk_active = 1'b0;
                if (len_q.size() == 0) begin
                    fail_event("unexpected_done");
                end else begin
                    mon_len = len_q.pop_front();
                    check32("words_sent_at_done", words_sent, 32'(mon_len));
                    check32("done_after_last_write", 32'(prev_write), 32'(mon_len != 0));
                end
                check32("words_left_at_done", 32'(exp_q.size()), 32'd0);
            end
            prev_write = ep_if.ep_write;
        end
    end

    // ---------------- reference model ----------------
    task automatic push_expect(input int len, input logic [2:0] pat, input logic [31:0] fx);
        logic [31:0] s;
        logic [31:0] w;
        int rem;
        s = 32'h1;
        for (int i = 0; i < len; i++) begin
            case (pat)
                3'd0: w = fx;
                3'd1: w = 32'(i + 1);
                3'd3: w = 32'h1 << (i % 32);
                default: begin
                    w = s;
                    s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
                end
            endcase
            exp_q.push_back(w);
        end
        rem = len;
        while (rem > 0) begin
            blk_q.push_back((rem > BW) ? BW : rem);
            rem -= (rem > BW) ? BW : rem;
        end
        len_q.push_back(len);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_trace();
        wr_cyc_q.delete();
        strobe_cyc_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic set_throttle(input logic [31:0] v);
        throttle_set = 1'b1;
        throttle_val = v;
        tick();
        throttle_set = 1'b0;
    endtask

    task automatic issue_start(input int len, input logic [2:0] pat, input logic [31:0] fx);
        start = 1'b1;
        length = 32'(len);
        pattern = pat;
        fixed_pattern = fx;
        push_expect(len, pat, fx);
        done_base = done_total;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) fail_event("idle_timeout");
    endtask

    task automatic wait_done(input int budget, input bit rand_rdy, input int poke_at);
        int i;
        for (i = 0; i < budget && done_total <= done_base; i++) begin
            if (rand_rdy) ep_if.ep_ready = ($urandom_range(0, 3) != 0);
            if (i == poke_at && busy) begin
                start = 1'b1;
                length = 32'($urandom_range(1, 9));
                pattern = 3'($urandom_range(0, 7));
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        ep_if.ep_ready = 1'b1;
        if (done_total <= done_base) fail_event("done_timeout");
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c, w0, s0, n;
        logic [2:0] pat;
        ep_if.ep_ready = 1'b1;

        // Reset values.
        repeat (3) tick();
        check32("rst_write", 32'(ep_if.ep_write), 32'd0);
        check32("rst_strobe", 32'(ep_if.ep_blockstrobe), 32'd0);
        check32("rst_data", ep_if.ep_dataout, 32'h0);
        check32("rst_busy", 32'(busy), 32'd0);
        check32("rst_done", 32'(done), 32'd0);
        check32("rst_words_sent", words_sent, 32'h0);
        check32("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        tick();

        // Counter, single block: strobe at N+2, writes N+3..N+6, done N+7.
        clear_trace();
        c = cyc;
        issue_start(4, 3'd1, 32'h0);
        check32("busy_after_start", 32'(busy), 32'd1);
        wait_done(100, 1'b0, -1);
        check32("t1_strobes", 32'(strobe_cyc_q.size()), 32'd1);
        if (strobe_cyc_q.size() == 1) check32("t1_strobe_cycle", 32'(strobe_cyc_q[0]), 32'(c + 2));
        check32("t1_writes", 32'(wr_cyc_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_cyc_q.size(); i++)
            check32("t1_write_cycle", 32'(wr_cyc_q[i]), 32'(c + 3 + i));
        if (done_cyc_q.size() == 1) check32("t1_done_cycle", 32'(done_cyc_q[0]), 32'(c + 7));
        else fail_event("t1_done_count");
        tick();
        check32("t1_busy_cleared", 32'(busy), 32'd0);
        check32("t1_words_held", words_sent, 32'd4);

        // LFSR: 1, 3, 6.
        wait_idle();
        issue_start(3, 3'd2, 32'h0);
        wait_done(100, 1'b0, -1);

        // Throttle 0xAAAAAAAA: writes every other cycle within a block.
        wait_idle();
        set_throttle(32'hAAAA_AAAA);
        clear_trace();
        issue_start(8, 3'd3, 32'h0);
        wait_done(200, 1'b0, -1);
        check32("t3_writes", 32'(wr_cyc_q.size()), 32'd8);
        if (wr_cyc_q.size() == 8) begin
            for (int i = 0; i < 7; i++)
                if (i != 3) check32("t3_write_gap", 32'(wr_cyc_q[i + 1] - wr_cyc_q[i]), 32'd2);
        end
        wait_idle();
        set_throttle(32'hFFFF_FFFF);

        // Stall and short block.
        wait_idle();
        clear_trace();
        issue_start(6, 3'd1, 32'h0);
        n = 0;
        while (strobe_cyc_q.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        ep_if.ep_ready = 1'b0;
        repeat (15) tick();
        check32("t4_stall_strobes", 32'(strobe_cyc_q.size()), 32'd1);
        check32("t4_stall_writes", 32'(wr_cyc_q.size()), 32'd4);
        ep_if.ep_ready = 1'b1;
        wait_done(100, 1'b0, -1);
        check32("t4_strobes", 32'(strobe_cyc_q.size()), 32'd2);
        check32("t4_writes", 32'(wr_cyc_q.size()), 32'd6);

        // Reset mid-burst after 2 of 8 writes.
        wait_idle();
        w0 = wr_total;
        issue_start(8, 3'd1, 32'h0);
        n = 0;
        while (wr_total < w0 + 2 && n < 50) begin
            tick();
            n++;
        end
        rst = 1'b1;
        exp_q.delete();
        blk_q.delete();
        len_q.delete();
        tick();
        check32("t5_write", 32'(ep_if.ep_write), 32'd0);
        check32("t5_strobe", 32'(ep_if.ep_blockstrobe), 32'd0);
        check32("t5_data", ep_if.ep_dataout, 32'h0);
        check32("t5_busy", 32'(busy), 32'd0);
        check32("t5_words_sent", words_sent, 32'h0);
        check32("t5_state", 32'(dbg_state), 32'(IDLE));
        check32("t5_writes_before_reset", 32'(wr_total - w0), 32'd2);
        rst = 1'b0;
        tick();
        clear_trace();
        issue_start(2, 3'd1, 32'h0);
        wait_done(100, 1'b0, -1);
        check32("t5_restart_writes", 32'(wr_cyc_q.size()), 32'd2);

        // Zero length.
        wait_idle();
        s0 = strobe_total;
        w0 = wr_total;
        issue_start(0, 3'd1, 32'h0);
        wait_done(20, 1'b0, -1);
        check32("t6_zero_strobes", 32'(strobe_total - s0), 32'd0);
        check32("t6_zero_writes", 32'(wr_total - w0), 32'd0);

        // Start while busy is dropped.
        wait_idle();
        w0 = wr_total;
        issue_start(8, 3'd1, 32'h0);
        start = 1'b1;
        length = 32'd5;
        pattern = 3'd2;
        tick();
        start = 1'b0;
        wait_done(100, 1'b0, -1);
        repeat (8) tick();
        check32("t6_busy_start_writes", 32'(wr_total - w0), 32'd8);

        // Randomized transfers with random ready, throttle and busy starts.
        for (int k = 0; k < 12; k++) begin
            wait_idle();
            if ($urandom_range(0, 2) == 0) set_throttle($urandom | 32'h1);
            else set_throttle(32'hFFFF_FFFF);
            pat = 3'($urandom_range(0, 7));
            issue_start(int'($urandom_range(0, 13)), pat, $urandom);
            wait_done(1500, 1'b1, int'($urandom_range(1, 20)));
        end

        wait_idle();
        repeat (5) tick();
        check32("final_exp_empty", 32'(exp_q.size()), 32'd0);
        check32("final_len_empty", 32'(len_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
